// File: rtl/ldm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_sequencer
//
// Purpose: sequences an ARM-style load-multiple (LDMIA / LDMDB). It turns the
// decoder's 16-bit register list into one memory read per listed register,
// writes each returned word to the register file on the following cycle, and
// optionally writes the updated base back to Rn at the end.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   one-cycle request, honoured only in IDLE
//   base_val    in  32   current value of base register Rn
//   ra          in   4   base register index
//   reg_mask    in  16   register list, bit i set = load Ri
//   wback       in   1   base writeback requested
//   dec_before  in   1   1 = decrement before (DB), 0 = increment after (IA)
//   mem_req     out  1   memory read request
//   mem_addr    out 32   address of the current beat
//   mem_rdy     in   1   memory accept, mem_rdata valid in the same cycle
//   mem_rdata   in  32   read data
//   rf_we       out  1   register-file write enable (registered)
//   rf_waddr    out  4   register-file write index (registered)
//   rf_wdata    out 32   register-file write data (registered)
//   busy        out  1   high in every state except IDLE
//   done        out  1   one-cycle completion pulse
//   err         out  1   one-cycle pulse for an empty register list
// ---------------------------------------------------------------------------
module ldm_sequencer #(
  parameter int WORD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_val,
  input  logic [3:0]  ra,
  input  logic [15:0] reg_mask,
  input  logic        wback,
  input  logic        dec_before,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Number of registers in the list (0..16).
  function automatic logic [4:0] popcount16(input logic [15:0] m);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, m[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit; the list is loaded in ascending order.
  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;          // registers still to be loaded
  logic [3:0]  ra_q, ra_d;
  logic        wback_q, wback_d;
  logic        base_in_list_q, base_in_list_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbval_q, wbval_d;
  logic        err_q, err_d;
  logic        rf_we_q, rf_we_d;
  logic [3:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic [4:0]  cnt;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] wb_val;
  logic [15:0] rem_next;

  // Address arithmetic for a new request, evaluated on the live decoder
  // inputs and captured only when the request is accepted in IDLE.
  always_comb begin
    cnt        = popcount16(reg_mask);
    span       = 32'(cnt) * STEP;
    start_addr = dec_before ? (base_val - span) : base_val;
    wb_val     = dec_before ? (base_val - span) : (base_val + span);
  end

  // Clearing the lowest set bit retires the register being accepted.
  assign rem_next = rem_q & (rem_q - 16'd1);

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    ra_d           = ra_q;
    wback_d        = wback_q;
    base_in_list_d = base_in_list_q;
    addr_d         = addr_q;
    wbval_d        = wbval_q;
    err_d          = err_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = '0;
    rf_wdata_d     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (reg_mask != 16'd0) begin
            rem_d          = reg_mask;
            ra_d           = ra;
            wback_d        = wback;
            base_in_list_d = reg_mask[ra];
            addr_d         = start_addr;
            wbval_d        = wb_val;
            err_d          = 1'b0;
            state_d        = S_LOAD;
          end else begin
            // Empty list: report and finish without touching memory or
            // the register file (wback cleared so DONE writes nothing).
            wback_d = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_LOAD: begin
        if (mem_rdy) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = lowest_idx(rem_q);
          rf_wdata_d = mem_rdata;
          rem_d      = rem_next;
          addr_d     = addr_q + STEP;
          if (rem_next == 16'd0) state_d = S_WB;
        end
      end

      S_WB: begin
        // Writeback is registered here so it appears in DONE, one cycle
        // after the last data write; the two never share a cycle. A base
        // that was itself in the list keeps its loaded value.
        if (wback_q && !base_in_list_q) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = ra_q;
          rf_wdata_d = wbval_q;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        err_d   = 1'b0;
        wback_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rem_q          <= '0;
      ra_q           <= '0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      addr_q         <= '0;
      wbval_q        <= '0;
      err_q          <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      ra_q           <= ra_d;
      wback_q        <= wback_d;
      base_in_list_q <= base_in_list_d;
      addr_q         <= addr_d;
      wbval_q        <= wbval_d;
      err_q          <= err_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
    end
  end

  assign mem_req  = (state_q == S_LOAD);
  assign mem_addr = mem_req ? addr_q : 32'd0;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done && err_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
